// File: rtl/alu_dispatch_pkg.sv
// alu_dispatch_pkg: opcode encoding and default widths shared by the
// operand dispatch stage and its FIFO.
package alu_dispatch_pkg;

  // Opcode selects the logic unit whose result is captured
  typedef logic [1:0] op_t;

  localparam op_t OP_AND = 2'd0;
  localparam op_t OP_OR  = 2'd1;
  localparam op_t OP_XOR = 2'd2;
  localparam op_t OP_ADD = 2'd3;

  localparam int DATA_W_DEF = 8;
  localparam int TAG_W_DEF  = 2;
  localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/alu_op_dispatch_op_fifo.sv
// op_fifo: DEPTH-entry request buffer with wrapping pointers and an
// occupancy counter. Push is ignored when full, pop when empty, and
// flush discards everything (including a same-cycle push).
module op_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == {CNT_W{1'b0}});
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Qualify push/pop against current occupancy
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Entry storage; written only on an accepted, non-flushed push
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_dispatch.sv
// alu_op_dispatch: buffers tagged requests, issues one per cycle onto the
// shared operand bus (fu_a/fu_b) and returns the selected unit result with
// its tag. Optional macro ALU_DISPATCH_COUNT_EN adds a 16-bit op_count of
// completed results.
module alu_op_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  op_t                   in_op,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic [DATA_W-1:0]     fu_a,
  output logic [DATA_W-1:0]     fu_b,
  input  logic [4*DATA_W-1:0]   fu_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_zero
`ifdef ALU_DISPATCH_COUNT_EN
  ,
  output logic [15:0]           op_count
`endif
);

  localparam int ENTRY_W = 2 + TAG_W + 2 * DATA_W;

  logic [ENTRY_W-1:0]    fifo_wr_s;
  logic [ENTRY_W-1:0]    fifo_rd_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [$clog2(DEPTH):0] fifo_count_s;
  logic                  unused_count_s;

  op_t                   head_op_s;
  logic [TAG_W-1:0]      head_tag_s;
  logic [DATA_W-1:0]     head_a_s;
  logic [DATA_W-1:0]     head_b_s;

  logic                  push_s;
  logic                  pop_s;
  logic                  res_free_s;
  logic                  iss_adv_s;
  logic [DATA_W-1:0]     sel_res_s;

  op_t                   iss_op_r;
  logic [TAG_W-1:0]      iss_tag_r;
  logic                  iss_valid_r;

  assign fifo_wr_s = {in_op, in_tag, in_a, in_b};
  assign {head_op_s, head_tag_s, head_a_s, head_b_s} = fifo_rd_s;
  assign in_ready  = !fifo_full_s;
  // Occupancy is kept for debug visibility; control only needs full/empty
  assign unused_count_s = ^fifo_count_s;

  op_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (fifo_wr_s),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Pipeline handshake: result slot frees on consume, issue advances into it,
  // FIFO head loads when the issue slot is empty or moving on
  always_comb begin
    push_s     = in_valid && !fifo_full_s;
    res_free_s = !out_valid || out_ready;
    iss_adv_s  = iss_valid_r && res_free_s;
    pop_s      = !fifo_empty_s && (!iss_valid_r || res_free_s);
  end

  // Pick the unit result matching the issued opcode
  always_comb begin
    case (iss_op_r)
      OP_AND:  sel_res_s = fu_res[0*DATA_W +: DATA_W];
      OP_OR:   sel_res_s = fu_res[1*DATA_W +: DATA_W];
      OP_XOR:  sel_res_s = fu_res[2*DATA_W +: DATA_W];
      OP_ADD:  sel_res_s = fu_res[3*DATA_W +: DATA_W];
      default: sel_res_s = fu_res[0*DATA_W +: DATA_W];
    endcase
  end

  // Issue register; operands stay stable on the bus while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_r <= 1'b0;
      iss_op_r    <= OP_AND;
      iss_tag_r   <= {TAG_W{1'b0}};
      fu_a        <= {DATA_W{1'b0}};
      fu_b        <= {DATA_W{1'b0}};
    end else if (flush) begin
      iss_valid_r <= 1'b0;
    end else if (pop_s) begin
      iss_valid_r <= 1'b1;
      iss_op_r    <= head_op_s;
      iss_tag_r   <= head_tag_s;
      fu_a        <= head_a_s;
      fu_b        <= head_b_s;
    end else if (iss_adv_s) begin
      iss_valid_r <= 1'b0;
    end
  end

  // Result register; holds while the consumer back-pressures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_tag   <= {TAG_W{1'b0}};
      out_zero  <= 1'b1;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (iss_adv_s) begin
      out_valid <= 1'b1;
      out_data  <= sel_res_s;
      out_tag   <= iss_tag_r;
      out_zero  <= (sel_res_s == {DATA_W{1'b0}});
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_DISPATCH_COUNT_EN
  // Completed-result counter, wraps at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= 16'd0;
    end else if (flush) begin
      op_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_dispatch.sv
// tb_alu_op_dispatch: directed bench for alu_op_dispatch. The logic units
// are modelled combinationally from fu_a/fu_b; expected results are
// hand-computed constants.
module tb_alu_op_dispatch;
  import alu_dispatch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  op_t         in_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [1:0]  in_tag;
  logic [7:0]  fu_a;
  logic [7:0]  fu_b;
  logic [31:0] fu_res;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_tag;
  logic        out_zero;
`ifdef ALU_DISPATCH_COUNT_EN
  logic [15:0] op_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  alu_op_dispatch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .fu_a      (fu_a),
    .fu_b      (fu_b),
    .fu_res    (fu_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero)
`ifdef ALU_DISPATCH_COUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  // Shared logic units: slice k answers opcode k
  assign fu_res = {fu_a + fu_b, fu_a ^ fu_b, fu_a | fu_b, fu_a & fu_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_v(input string name, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", name, obs, exp);
    end
  endtask

  task automatic chk_res(input string name, input logic [7:0] d, input logic [1:0] t);
    chk_b({name, "_valid"}, out_valid, 1'b1);
    chk_v({name, "_data"}, 16'(out_data), 16'(d));
    chk_v({name, "_tag"}, 16'(out_tag), 16'(t));
    chk_b({name, "_zero"}, out_zero, (d == 8'h00));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input op_t op, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] t);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
  endtask

  task automatic chk_reset_vals(input string name);
    chk_b({name, "_in_ready"}, in_ready, 1'b1);
    chk_b({name, "_out_valid"}, out_valid, 1'b0);
    chk_v({name, "_out_data"}, 16'(out_data), 16'h0000);
    chk_v({name, "_out_tag"}, 16'(out_tag), 16'h0000);
    chk_b({name, "_out_zero"}, out_zero, 1'b1);
    chk_v({name, "_fu_a"}, 16'(fu_a), 16'h0000);
    chk_v({name, "_fu_b"}, 16'(fu_b), 16'h0000);
  endtask

  initial begin
    logic [7:0] t2_exp [4];
    logic [7:0] t3_a   [7];
    logic [7:0] t3_exp [7];
    logic [7:0] t6_exp [3];
    t2_exp = '{8'h01, 8'hFF, 8'hFE, 8'h00};
    t3_a   = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    t3_exp = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67};
    t6_exp = '{8'h02, 8'hFF, 8'h00};

    // Reset state
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, OP_AND, 8'h00, 8'h00, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single XOR, 2-cycle latency
    drive(1'b1, OP_XOR, 8'hA5, 8'h0F, 2'd1);
    step();
    drive(1'b0, OP_AND, 8'h00, 8'h00, 2'd0);
    chk_b("t1_e0_valid", out_valid, 1'b0);
    step();
    chk_b("t1_e1_valid", out_valid, 1'b0);
    chk_v("t1_fu_a", 16'(fu_a), 16'h00A5);
    chk_v("t1_fu_b", 16'(fu_b), 16'h000F);
    step();
    chk_res("t1_res", 8'hAA, 2'd1);
    step();
    chk_b("t1_drained", out_valid, 1'b0);

    // Back-to-back AND/OR/XOR/ADD, one result per cycle
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, op_t'(c), 8'hFF, 8'h01, 2'(c));
      else       drive(1'b0, OP_AND, 8'h00, 8'h00, 2'd0);
      step();
      if (c >= 2) chk_res($sformatf("t2_res%0d", c - 2), t2_exp[c-2], 2'(c - 2));
    end
    step();
    chk_b("t2_drained", out_valid, 1'b0);

    // Back-pressure: 6 ops fill result + issue + 4 FIFO entries
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, OP_ADD, t3_a[i], 8'h01, 2'(i));
      chk_b($sformatf("t3_ready%0d", i), in_ready, 1'b1);
      step();
    end
    drive(1'b0, OP_AND, 8'h00, 8'h00, 2'd0);
    for (int s = 0; s < 3; s++) begin
      chk_b($sformatf("t3_full%0d", s), in_ready, 1'b0);
      chk_v($sformatf("t3_fu_a%0d", s), 16'(fu_a), 16'h0011);
      chk_v($sformatf("t3_fu_b%0d", s), 16'(fu_b), 16'h0001);
      chk_res($sformatf("t3_hold%0d", s), 8'h01, 2'd0);
      if (s < 2) step();
    end

    // Full FIFO: pop and push in same cycle -> push refused, taken next cycle
    drive(1'b1, OP_ADD, t3_a[6], 8'h01, 2'd2);
    out_ready = 1'b1;
    step();
    chk_b("t4_ready_after_pop", in_ready, 1'b1);
    chk_res("t4_res1", t3_exp[1], 2'd1);
    step();
    drive(1'b0, OP_AND, 8'h00, 8'h00, 2'd0);
    chk_res("t4_res2", t3_exp[2], 2'd2);
    for (int i = 3; i < 7; i++) begin
      step();
      chk_res($sformatf("t4_res%0d", i), t3_exp[i], (i == 6) ? 2'd2 : 2'(i));
    end
    step();
    chk_b("t4_no_dup", out_valid, 1'b0);
`ifdef ALU_DISPATCH_COUNT_EN
    chk_v("t4_op_count", op_count, 16'd12);
`endif

    // Flush with 3 ops in flight and a same-cycle push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_ADD, 8'(i + 1), 8'h00, 2'(i));
      step();
    end
    chk_b("t5_pre_valid", out_valid, 1'b1);
    drive(1'b1, OP_ADD, 8'h77, 8'h00, 2'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, OP_AND, 8'h00, 8'h00, 2'd0);
    chk_b("t5_valid", out_valid, 1'b0);
    chk_b("t5_ready", in_ready, 1'b1);
`ifdef ALU_DISPATCH_COUNT_EN
    chk_v("t5_op_count", op_count, 16'd0);
`endif
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk_b($sformatf("t5_empty%0d", s), out_valid, 1'b0);
    end

    // Asynchronous reset mid-burst
    out_ready = 1'b0;
    drive(1'b1, OP_OR, 8'h40, 8'h02, 2'd1);
    step();
    drive(1'b1, OP_OR, 8'h33, 8'h04, 2'd2);
    step();
    drive(1'b0, OP_AND, 8'h00, 8'h00, 2'd0);
    step();
    chk_res("t6_pre", 8'h42, 2'd1);
    chk_v("t6_pre_fu_a", 16'(fu_a), 16'h0033);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
`ifdef ALU_DISPATCH_COUNT_EN
    chk_v("t6_op_count_rst", op_count, 16'd0);
`endif
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       drive(1'b1, OP_ADD, 8'h01, 8'h01, 2'd1);
        1:       drive(1'b1, OP_XOR, 8'h0F, 8'hF0, 2'd2);
        2:       drive(1'b1, OP_AND, 8'hF0, 8'h0F, 2'd3);
        default: drive(1'b0, OP_AND, 8'h00, 8'h00, 2'd0);
      endcase
      step();
      if (c >= 2) chk_res($sformatf("t6_res%0d", c - 2), t6_exp[c-2], 2'(c - 1));
    end
    step();
    chk_b("t6_drained", out_valid, 1'b0);
`ifdef ALU_DISPATCH_COUNT_EN
    chk_v("t6_op_count", op_count, 16'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
